riscv_div_issue_ctrl: RTL and testbench
=======================================

# riscv_div_issue_ctrl

- Execute-stage initiator for the iterative 64-bit divider.
- Accepts DIV/DIVU/REM/REMU requests from the pipeline and holds the pipeline in stall while a division runs.
- Drives the divider's control and operand inputs, captures the result on the divider's valid pulse, and returns it with a one-cycle done.
- Absorbs the divider's re-arm run so that only one real division is ever in flight.

## Interface
Parameters:
- XLEN, 64, operand/result width; fixed at 64.

Ports:
- i_riscv_div_clk  in  1  clock; reset i_riscv_div_rst, asynchronous, active-low.
- i_riscv_div_rst  in  1  asynchronous active-low reset.
- i_riscv_divctl_req  in  1  pipeline request; held high until done.
- i_riscv_divctl_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_riscv_divctl_rs1data / i_riscv_divctl_rs2data  in  64  dividend / divisor.
- i_riscv_divctl_flush  in  1  abandon current request.
- o_riscv_divctl_stall  out  1  combinational; req && !done.
- o_riscv_divctl_done  out  1  registered one-cycle completion pulse.
- o_riscv_divctl_result  out  64  registered; valid while done is high, otherwise holds its last value.
- o_riscv_divctl_divctrl  out  3  to divider: {start, op}; registered.
- o_riscv_divctl_div_rs1data / o_riscv_divctl_div_rs2data  out  64  registered operands to divider.
- i_riscv_divctl_divresult  in  64  divider result.
- i_riscv_divctl_divvalid  in  1  divider valid pulse.

## Operation
Divider contract (fixed):
- Divider samples divctrl[2] only in its idle state.
- Its result is decoded combinationally from divctrl and the operands, so both must stay stable through the valid cycle.
- The valid cycle is idle, so a still-high divctrl[2] re-arms one extra run, ending in one extra valid.

States:
- IDLE: on req && !flush, register divctrl={1,op} and the operands, then go to WAIT. Flush wins over req.
- WAIT: hold divctrl and operands.
  - On divvalid: register result, pulse done, clear divctrl to 000, go to DRAIN. The divider has re-armed.
  - On flush without divvalid: clear divctrl and go to DRAIN. No done; exactly one valid is still pending.
  - Flush in the same cycle as divvalid: flush wins. No done; go to DRAIN.
- DRAIN: ignore the divider result. On divvalid go to IDLE. Requests pending here stay stalled. Flush has no effect.

Other rules:
- Reset values: state IDLE, divctrl 000, operands 0, result 0, done 0, cache invalid.
- Reset mid-operation returns to IDLE. The divider shares the reset, so nothing is pending.
- Division-by-zero and overflow results pass through unmodified from the divider.

## Timing
- Request first high in IDLE at cycle T:
  - divctrl={1,op} visible at T+1.
  - Divider computes T+2..T+65.
  - divvalid high at T+66.
  - done and result at T+67.
  - Stall low at T+67.
- Re-arm run: divvalid at T+131, IDLE at T+132.
- A back-to-back request is accepted at T+132 and completes at T+199.
- Stall is never low without done for an accepted request. Done never pulses after a flush.

## Configuration
RISCV_DIV_RESULT_CACHE_EN:
- Defined: keep a one-entry cache of {op, rs1, rs2, result}, written on every done.
  - A request in IDLE or DRAIN matching the cache produces done and the cached result one cycle after req rises, with no divider issue.
  - DRAIN continues unaffected. The cache is invalidated only by reset.
- Undefined: no cache; every request issues to the divider.

## Test plan
- DIV 100/7 (op 00) at T → divctrl 100 at T+1, done at T+67 with result 14, stall low at T+67.
- REM -7/2 (op 10) → result -1. DIVU 1/0 (op 01) → result 0xFFFF_FFFF_FFFF_FFFF.
- Back-to-back DIV then REMU 9/4 (op 11) held high → second divctrl issued at T+132, done at T+199 with result 1. No done at T+131.
- Flush at T+30 → divctrl 000 at T+31, no done ever. DRAIN exits on the T+66 valid; next request accepted at T+67.
- Cache enabled, DIVU 50/5 repeated after completion → done one cycle after req with result 10, divctrl stays 000. Cache disabled → full 67-cycle latency.
- Reset asserted at T+40 → all outputs 0 immediately, state IDLE. New request after release completes normally.

Source files
------------

// File: rtl/riscv_div_issue_ctrl.sv
// Execute-stage issue controller for the iterative 64-bit divider: issues one division, stalls the
// pipeline, returns the result with a done pulse and absorbs the divider's re-arm run.
// Optional one-entry result cache enabled by defining RISCV_DIV_RESULT_CACHE_EN.
module riscv_div_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_div_clk,
    input  logic            i_riscv_div_rst,
    input  logic            i_riscv_divctl_req,
    input  logic [1:0]      i_riscv_divctl_op,
    input  logic [XLEN-1:0] i_riscv_divctl_rs1data,
    input  logic [XLEN-1:0] i_riscv_divctl_rs2data,
    input  logic            i_riscv_divctl_flush,
    output logic            o_riscv_divctl_stall,
    output logic            o_riscv_divctl_done,
    output logic [XLEN-1:0] o_riscv_divctl_result,
    output logic [2:0]      o_riscv_divctl_divctrl,
    output logic [XLEN-1:0] o_riscv_divctl_div_rs1data,
    output logic [XLEN-1:0] o_riscv_divctl_div_rs2data,
    input  logic [XLEN-1:0] i_riscv_divctl_divresult,
    input  logic            i_riscv_divctl_divvalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e          state_r, state_s;
    logic [2:0]      divctrl_r, divctrl_s;
    logic [XLEN-1:0] rs1_r, rs1_s;
    logic [XLEN-1:0] rs2_r, rs2_s;
    logic [XLEN-1:0] result_r, result_s;
    logic            done_r, done_s;
    logic            accept_s;
    logic            hit_s;
    logic [XLEN-1:0] cache_res_s;

    // A held request is new only when its own completion is not being presented this cycle
    assign accept_s = i_riscv_divctl_req && !i_riscv_divctl_flush && !done_r;

`ifdef RISCV_DIV_RESULT_CACHE_EN
    logic            cache_we_s;
    logic            cache_vld_r;
    logic [1:0]      cache_op_r;
    logic [XLEN-1:0] cache_rs1_r;
    logic [XLEN-1:0] cache_rs2_r;
    logic [XLEN-1:0] cache_res_r;

    assign cache_we_s = (state_r == ST_WAIT) && i_riscv_divctl_divvalid && !i_riscv_divctl_flush;

    // Cache entry holds the most recent divider-computed result and its key
    always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst) begin
        if (!i_riscv_div_rst) begin
            cache_vld_r <= 1'b0;
            cache_op_r  <= 2'b00;
            cache_rs1_r <= {XLEN{1'b0}};
            cache_rs2_r <= {XLEN{1'b0}};
            cache_res_r <= {XLEN{1'b0}};
        end else if (cache_we_s) begin
            cache_vld_r <= 1'b1;
            cache_op_r  <= divctrl_r[1:0];
            cache_rs1_r <= rs1_r;
            cache_rs2_r <= rs2_r;
            cache_res_r <= i_riscv_divctl_divresult;
        end
    end

    assign hit_s = cache_vld_r && (i_riscv_divctl_op == cache_op_r) &&
                   (i_riscv_divctl_rs1data == cache_rs1_r) && (i_riscv_divctl_rs2data == cache_rs2_r);
    assign cache_res_s = cache_res_r;
`else
    assign hit_s       = 1'b0;
    assign cache_res_s = {XLEN{1'b0}};
`endif

    // Next-state and next-output decode
    always_comb begin
        state_s   = state_r;
        divctrl_s = divctrl_r;
        rs1_s     = rs1_r;
        rs2_s     = rs2_r;
        result_s  = result_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && hit_s) begin
                    result_s = cache_res_s;
                    done_s   = 1'b1;
                end else if (accept_s) begin
                    divctrl_s = {1'b1, i_riscv_divctl_op};
                    rs1_s     = i_riscv_divctl_rs1data;
                    rs2_s     = i_riscv_divctl_rs2data;
                    state_s   = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The divider re-arms on the valid cycle either way, so both exits drain one run
                if (i_riscv_divctl_flush) begin
                    divctrl_s = 3'b000;
                    state_s   = ST_DRAIN;
                end else if (i_riscv_divctl_divvalid) begin
                    result_s  = i_riscv_divctl_divresult;
                    done_s    = 1'b1;
                    divctrl_s = 3'b000;
                    state_s   = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (i_riscv_divctl_divvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
                if (accept_s && hit_s) begin
                    result_s = cache_res_s;
                    done_s   = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                divctrl_s = 3'b000;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst) begin
        if (!i_riscv_div_rst) begin
            state_r   <= ST_IDLE;
            divctrl_r <= 3'b000;
            rs1_r     <= {XLEN{1'b0}};
            rs2_r     <= {XLEN{1'b0}};
            result_r  <= {XLEN{1'b0}};
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            divctrl_r <= divctrl_s;
            rs1_r     <= rs1_s;
            rs2_r     <= rs2_s;
            result_r  <= result_s;
            done_r    <= done_s;
        end
    end

    assign o_riscv_divctl_stall       = i_riscv_divctl_req && !done_r;
    assign o_riscv_divctl_done        = done_r;
    assign o_riscv_divctl_result      = result_r;
    assign o_riscv_divctl_divctrl     = divctrl_r;
    assign o_riscv_divctl_div_rs1data = rs1_r;
    assign o_riscv_divctl_div_rs2data = rs2_r;

endmodule

// File: tb/tb_riscv_div_issue_ctrl.sv
// Self-checking bench for riscv_div_issue_ctrl with a behavioural 64-cycle re-arming divider.
module tb_riscv_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic [63:0] rs1, rs2;
    logic        flush;
    logic        stall, done;
    logic [63:0] result;
    logic [2:0]  divctrl;
    logic [63:0] d_rs1, d_rs2;
    logic [63:0] divresult;
    logic        divvalid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_div_issue_ctrl #(.XLEN(64)) dut (
        .i_riscv_div_clk            (clk),
        .i_riscv_div_rst            (rst),
        .i_riscv_divctl_req         (req),
        .i_riscv_divctl_op          (op),
        .i_riscv_divctl_rs1data     (rs1),
        .i_riscv_divctl_rs2data     (rs2),
        .i_riscv_divctl_flush       (flush),
        .o_riscv_divctl_stall       (stall),
        .o_riscv_divctl_done        (done),
        .o_riscv_divctl_result      (result),
        .o_riscv_divctl_divctrl     (divctrl),
        .o_riscv_divctl_div_rs1data (d_rs1),
        .o_riscv_divctl_div_rs2data (d_rs2),
        .i_riscv_divctl_divresult   (divresult),
        .i_riscv_divctl_divvalid    (divvalid)
    );

    // Divider model: starts from idle when divctrl[2] is high, valid 64 cycles later, result decoded live
    logic [6:0] dv_cnt;
    logic       dv_valid;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_cnt   <= 7'd0;
            dv_valid <= 1'b0;
        end else if (dv_cnt == 7'd0) begin
            dv_valid <= 1'b0;
            if (divctrl[2]) dv_cnt <= 7'd64;
        end else begin
            dv_cnt   <= dv_cnt - 7'd1;
            dv_valid <= (dv_cnt == 7'd1);
        end
    end

    function automatic logic [63:0] div_model(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        ovf;
        ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (f)
            2'b00:   r = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'($signed(a) / $signed(b)));
            2'b01:   r = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            2'b10:   r = (b == 64'd0) ? a : (ovf ? 64'd0 : 64'($signed(a) % $signed(b)));
            default: r = (b == 64'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    assign divresult = div_model(divctrl[1:0], d_rs1, d_rs2);
    assign divvalid  = dv_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (70) tick();
    endtask

    task automatic drive_req(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        req = 1'b1;
        op  = o;
        rs1 = a;
        rs2 = b;
    endtask

    task automatic wait_done(input int budget, output int dc, output logic [63:0] res, output logic st);
        dc  = -1;
        res = 64'd0;
        st  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                dc  = cyc;
                res = result;
                st  = stall;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; op = 2'b00; rs1 = 64'd0; rs2 = 64'd0; flush = 1'b0;
        tick(); tick();
        checks++;
        if (done !== 1'b0 || result !== 64'd0 || divctrl !== 3'b000 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b result=%h divctrl=%b stall=%b, required 0", done, result, divctrl, stall);
        end
        checks++;
        if (d_rs1 !== 64'd0 || d_rs2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_operands: rs1=%h rs2=%h, required 0", d_rs1, d_rs2);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_div_basic();
        int t; int dc; logic [63:0] res; logic st; logic [63:0] e;
        drive_req(2'b00, 64'd100, 64'd7);
        exp_q.push_back(64'd14);
        t = cyc;
        tick();
        checks++;
        if (divctrl !== 3'b100 || d_rs1 !== 64'd100 || d_rs2 !== 64'd7) begin
            errors++;
            $display("FAIL basic_issue: divctrl=%b rs1=%0d rs2=%0d, required 100 100 7", divctrl, d_rs1, d_rs2);
        end
        while (cyc < t + 66) tick();
        checks++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_stall_before_done: stall=%b done=%b, required 1 0", stall, done);
        end
        wait_done(10, dc, res, st);
        checks++;
        if (dc != t + 67) begin
            errors++;
            $display("FAIL basic_latency: done at %0d, required %0d", dc, t + 67);
        end
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("FAIL basic_stall_at_done: stall=%b, required 0", st);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL basic_result: got %h, required %h", res, e);
        end
        req = 1'b0;
    endtask

    task automatic test_results();
        logic [1:0]  to [2];
        logic [63:0] ta [2];
        logic [63:0] tb [2];
        logic [63:0] te [2];
        int t; int dc; logic [63:0] res; logic st; logic [63:0] e;
        to[0] = 2'b10; ta[0] = 64'hFFFF_FFFF_FFFF_FFF9; tb[0] = 64'd2; te[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        to[1] = 2'b01; ta[1] = 64'd1;                   tb[1] = 64'd0; te[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            settle();
            drive_req(to[i], ta[i], tb[i]);
            exp_q.push_back(te[i]);
            t = cyc;
            wait_done(80, dc, res, st);
            checks++;
            if (dc != t + 67) begin
                errors++;
                $display("FAIL result%0d_latency: done at %0d, required %0d", i, dc, t + 67);
            end
            e = exp_q.pop_front();
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL result%0d_value: got %h, required %h", i, res, e);
            end
            req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int t; int dc; logic [63:0] res; logic st; logic [63:0] e;
        settle();
        drive_req(2'b00, 64'd1000, 64'd10);
        exp_q.push_back(64'd100);
        t = cyc;
        wait_done(80, dc, res, st);
        checks++;
        if (dc != t + 67) begin
            errors++;
            $display("FAIL b2b_first_latency: done at %0d, required %0d", dc, t + 67);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL b2b_first_result: got %h, required %h", res, e);
        end
        drive_req(2'b11, 64'd9, 64'd4);
        exp_q.push_back(64'd1);
        while (cyc < t + 131) tick();
        checks++;
        if (done !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rearm_valid_ignored: done=%b stall=%b, required 0 1", done, stall);
        end
        tick();
        tick();
        checks++;
        if (divctrl !== 3'b111 || d_rs1 !== 64'd9 || d_rs2 !== 64'd4) begin
            errors++;
            $display("FAIL b2b_second_issue: divctrl=%b rs1=%0d rs2=%0d, required 111 9 4", divctrl, d_rs1, d_rs2);
        end
        wait_done(80, dc, res, st);
        checks++;
        if (dc != t + 199) begin
            errors++;
            $display("FAIL b2b_second_latency: done at %0d, required %0d", dc, t + 199);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL b2b_second_result: got %h, required %h", res, e);
        end
        req = 1'b0;
    endtask

    task automatic test_flush();
        int t; int dc; int spurious; logic [63:0] res; logic st; logic [63:0] e;
        settle();
        drive_req(2'b01, 64'd77, 64'd7);
        t = cyc;
        spurious = 0;
        while (cyc < t + 30) tick();
        flush = 1'b1;
        req   = 1'b0;
        tick();
        flush = 1'b0;
        checks++;
        if (divctrl !== 3'b000) begin
            errors++;
            $display("FAIL flush_clears_divctrl: divctrl=%b, required 000", divctrl);
        end
        while (cyc < t + 40) begin
            if (done !== 1'b0) spurious++;
            tick();
        end
        drive_req(2'b00, 64'd300, 64'hFFFF_FFFF_FFFF_FFFD);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF9C);
        while (cyc < t + 67) begin
            if (done !== 1'b0) spurious++;
            tick();
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL flush_no_done: %0d done cycles seen, required 0", spurious);
        end
        checks++;
        if (divctrl !== 3'b000 || stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain_hold: divctrl=%b stall=%b, required 000 1", divctrl, stall);
        end
        tick();
        checks++;
        if (divctrl !== 3'b100) begin
            errors++;
            $display("FAIL flush_next_issue: divctrl=%b, required 100", divctrl);
        end
        wait_done(80, dc, res, st);
        checks++;
        if (dc != t + 134) begin
            errors++;
            $display("FAIL flush_next_latency: done at %0d, required %0d", dc, t + 134);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL flush_next_result: got %h, required %h", res, e);
        end
        req = 1'b0;
    endtask

    task automatic test_cache();
        int t; int dc; logic [63:0] res; logic st; logic [63:0] e;
        settle();
        drive_req(2'b01, 64'd50, 64'd5);
        exp_q.push_back(64'd10);
        t = cyc;
        wait_done(80, dc, res, st);
        checks++;
        if (dc != t + 67) begin
            errors++;
            $display("FAIL cache_fill_latency: done at %0d, required %0d", dc, t + 67);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL cache_fill_result: got %h, required %h", res, e);
        end
        req = 1'b0;
        settle();
        drive_req(2'b01, 64'd50, 64'd5);
        exp_q.push_back(64'd10);
        t = cyc;
        wait_done(80, dc, res, st);
`ifdef RISCV_DIV_RESULT_CACHE_EN
        checks++;
        if (dc != t + 1 || divctrl !== 3'b000) begin
            errors++;
            $display("FAIL cache_hit: done at %0d divctrl=%b, required %0d 000", dc, divctrl, t + 1);
        end
`else
        checks++;
        if (dc != t + 67) begin
            errors++;
            $display("FAIL cache_off_latency: done at %0d, required %0d", dc, t + 67);
        end
`endif
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL cache_repeat_result: got %h, required %h", res, e);
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t; int dc; logic [63:0] res; logic st; logic [63:0] e;
        settle();
        drive_req(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        t = cyc;
        while (cyc < t + 40) tick();
        rst = 1'b0;
        req = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 64'd0 || divctrl !== 3'b000 || d_rs1 !== 64'd0 || d_rs2 !== 64'd0) begin
            errors++;
            $display("FAIL midreset_outputs: done=%b result=%h divctrl=%b rs1=%h rs2=%h, required 0",
                     done, result, divctrl, d_rs1, d_rs2);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        drive_req(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF2);
        t = cyc;
        wait_done(80, dc, res, st);
        checks++;
        if (dc != t + 67) begin
            errors++;
            $display("FAIL midreset_next_latency: done at %0d, required %0d", dc, t + 67);
        end
        e = exp_q.pop_front();
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL midreset_next_result: got %h, required %h", res, e);
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_results();
        test_back_to_back();
        test_flush();
        test_cache();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
